vga_timing_ctrl: RTL and testbench

Sequences VGA raster timing from the system clock, advancing one pixel per pixel clock-enable strobe from the pixel clock divider. It generates hsync, vsync, the active-video flag, pixel coordinates and line/frame start pulses for the pixel datapath. Run and stop requests from the host take effect only at frame boundaries, so a started frame is never truncated.

---
 rtl/vga_timing_ctrl_if.sv | 37 +++
 rtl/vga_timing_ctrl.sv | 147 ++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_ctrl_if.sv
// Timing bundle between the VGA timing controller (master) and the host/pixel datapath (slave).
// frame_cnt is present only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_ctrl_if #(
  parameter int CW = 10
) ();
  logic          pix_ce;
  logic          en;
  logic          hsync;
  logic          vsync;
  logic          active;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic          running;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0]   frame_cnt;

  modport master (
    input  pix_ce, en,
    output hsync, vsync, active, x, y, line_start, frame_start, running, frame_cnt
  );
  modport slave (
    output pix_ce, en,
    input  hsync, vsync, active, x, y, line_start, frame_start, running, frame_cnt
  );
`else
  modport master (
    input  pix_ce, en,
    output hsync, vsync, active, x, y, line_start, frame_start, running
  );
  modport slave (
    output pix_ce, en,
    input  hsync, vsync, active, x, y, line_start, frame_start, running
  );
`endif
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator; run/stop requests take effect only at frame boundaries.
// Optional macro VGA_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_ctrl #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int SYNC_ACT_HIGH = 0,
  parameter int CW            = 10
) (
  input logic             clk_in,
  input logic             resetn,
  vga_timing_ctrl_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  // Decode bounds are one bit wider so a sync window ending exactly at the total still fits.
  localparam logic [CW:0] H_VIS  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_VIS  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic SYNC_ON  = (SYNC_ACT_HIGH != 0);
  localparam logic SYNC_OFF = ~SYNC_ON;

  if ((H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_cw_too_small
    $error("vga_timing_ctrl: CW cannot hold H_TOTAL-1 / V_TOTAL-1");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOPPING = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] x_q, y_q, x_nxt, y_nxt;
  logic          hsync_q, vsync_q, active_q, ls_q, fs_q, running_q;
  logic          hsync_nxt, vsync_nxt, active_nxt, ls_nxt, fs_nxt, running_nxt;
  logic [CW:0]   xe, ye;

  always_comb begin
    state_nxt = state;
    x_nxt     = x_q;
    y_nxt     = y_q;
    ls_nxt    = 1'b0;
    fs_nxt    = 1'b0;
    case (state)
      IDLE: begin
        x_nxt = '0;
        y_nxt = '0;
        if (bus.en) begin
          state_nxt = RUN;
          ls_nxt    = 1'b1;
          fs_nxt    = 1'b1;
        end
      end
      RUN, STOPPING: begin
        state_nxt = bus.en ? RUN : STOPPING;
        if (bus.pix_ce) begin
          if (x_q != H_LAST) begin
            x_nxt = x_q + CW'(1);
          end else begin
            x_nxt  = '0;
            ls_nxt = 1'b1;
            if (y_q != V_LAST) begin
              y_nxt = y_q + CW'(1);
            end else begin
              y_nxt = '0;
              // A pending stop completes here; the wrap pulses are suppressed.
              if (state == STOPPING && !bus.en) begin
                state_nxt = IDLE;
                ls_nxt    = 1'b0;
              end else begin
                fs_nxt = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        x_nxt     = '0;
        y_nxt     = '0;
      end
    endcase

    running_nxt = (state_nxt != IDLE);
    xe          = {1'b0, x_nxt};
    ye          = {1'b0, y_nxt};
    active_nxt  = running_nxt && (xe < H_VIS) && (ye < V_VIS);
    hsync_nxt   = (running_nxt && xe >= HS_BEG && xe < HS_END) ? SYNC_ON : SYNC_OFF;
    vsync_nxt   = (running_nxt && ye >= VS_BEG && ye < VS_END) ? SYNC_ON : SYNC_OFF;
  end

  always_ff @(posedge clk_in) begin
    if (!resetn) begin
      state     <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      hsync_q   <= SYNC_OFF;
      vsync_q   <= SYNC_OFF;
      active_q  <= 1'b0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      x_q       <= x_nxt;
      y_q       <= y_nxt;
      hsync_q   <= hsync_nxt;
      vsync_q   <= vsync_nxt;
      active_q  <= active_nxt;
      ls_q      <= ls_nxt;
      fs_q      <= fs_nxt;
      running_q <= running_nxt;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Counts wrap frame_starts only; the pulse issued when leaving IDLE is excluded.
  always_ff @(posedge clk_in) begin
    if (!resetn) begin
      frame_cnt_q <= '0;
    end else if (fs_nxt && state != IDLE) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
`endif

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.active      = active_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;
  assign bus.running     = running_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl using a reduced raster (19 x 13) so whole frames are short.
// Define VGA_FRAME_CNT_EN to also exercise the frame counter.
module tb_vga_timing_ctrl;
  localparam int HA = 10, HFP = 2, HS = 3, HBP = 4;
  localparam int VA = 6,  VFP = 2, VS = 2, VBP = 3;
  localparam int CW = 6;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int OW = 6 + 2 * CW;

  logic clk_in = 1'b0;
  logic resetn;
  int   checks = 0;
  int   failures = 0;

  vga_timing_ctrl_if #(.CW(CW)) bus ();

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_ACT_HIGH(0), .CW(CW)
  ) dut (
    .clk_in(clk_in),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  logic [OW-1:0] dut_vec;
  assign dut_vec = {bus.running, bus.active, bus.hsync, bus.vsync,
                    bus.line_start, bus.frame_start, bus.x, bus.y};

  // Reference model: mode 0=idle 1=run 2=stopping, position as linear pixel index within a frame.
  int          m_mode = 0;
  int          m_pix = 0;
  logic        m_ls = 1'b0;
  logic        m_fs = 1'b0;
  logic [15:0] m_fc = 16'd0;

  function automatic logic [OW-1:0] mk(logic run, logic act, logic hs, logic vs,
                                       logic ls, logic fs, int px, int py);
    return {run, act, hs, vs, ls, fs, CW'(px), CW'(py)};
  endfunction

  function automatic logic [OW-1:0] model_out();
    int   mx, my;
    logic on, act, hs, vs;
    on  = (m_mode != 0);
    mx  = on ? m_pix % HT : 0;
    my  = on ? m_pix / HT : 0;
    act = on && mx < HA && my < VA;
    hs  = !(on && mx >= HA + HFP && mx < HA + HFP + HS);
    vs  = !(on && my >= VA + VFP && my < VA + VFP + VS);
    return mk(on, act, hs, vs, m_ls, m_fs, mx, my);
  endfunction

  task automatic model_step(input logic rn, input logic en, input logic ce);
    if (!rn) begin
      m_mode = 0; m_pix = 0; m_ls = 1'b0; m_fs = 1'b0; m_fc = 16'd0;
    end else if (m_mode == 0) begin
      m_pix = 0; m_ls = en; m_fs = en;
      if (en) m_mode = 1;
    end else begin
      m_ls = 1'b0; m_fs = 1'b0;
      if (ce) begin
        if (m_pix == FRAME - 1) begin
          m_pix = 0;
          if (m_mode == 2 && !en) begin
            m_mode = 0;
          end else begin
            m_ls = 1'b1; m_fs = 1'b1; m_fc = m_fc + 16'd1;
          end
        end else begin
          m_pix = m_pix + 1;
          m_ls = ((m_pix % HT) == 0);
        end
      end
      if (m_mode != 0) m_mode = en ? 1 : 2;
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic en, input logic ce);
    resetn     = rn;
    bus.en     = en;
    bus.pix_ce = ce;
    @(posedge clk_in);
    model_step(rn, en, ce);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [OW-1:0] exp);
    checks++;
    if (dut_vec !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got {run,act,hs,vs,ls,fs,x,y}=%h required %h", name, dut_vec, exp);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic ce);
    applyStimulus(1'b1, en, ce);
    checkOutput("model", model_out());
`ifdef VGA_FRAME_CNT_EN
    checkVal("frame_cnt_model", int'(bus.frame_cnt), int'(m_fc));
`endif
  endtask

  typedef struct {
    logic          rn, en, ce;
    logic [OW-1:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int   n, vcnt, acnt, fs_seen, drops;
    logic found;

    tbl[0] = '{1'b0, 1'b1, 1'b1, mk(0, 0, 1, 1, 0, 0, 0, 0)};
    tbl[1] = '{1'b0, 1'b1, 1'b0, mk(0, 0, 1, 1, 0, 0, 0, 0)};
    tbl[2] = '{1'b1, 1'b0, 1'b1, mk(0, 0, 1, 1, 0, 0, 0, 0)};
    tbl[3] = '{1'b1, 1'b1, 1'b1, mk(1, 1, 1, 1, 1, 1, 0, 0)};
    tbl[4] = '{1'b1, 1'b1, 1'b0, mk(1, 1, 1, 1, 0, 0, 0, 0)};
    tbl[5] = '{1'b1, 1'b1, 1'b1, mk(1, 1, 1, 1, 0, 0, 1, 0)};
    tbl[6] = '{1'b1, 1'b0, 1'b1, mk(1, 1, 1, 1, 0, 0, 2, 0)};
    tbl[7] = '{1'b1, 1'b1, 1'b1, mk(1, 1, 1, 1, 0, 0, 3, 0)};

    resetn = 1'b0; bus.en = 1'b0; bus.pix_ce = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].rn, tbl[i].en, tbl[i].ce);
      checkOutput($sformatf("vec%0d", i), tbl[i].exp);
    end

    // pix_ce every 4th cycle across the hsync window and the first line wrap
    for (int s = 0; s < HT - 3; s++) begin
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      if (m_pix == HA + HFP)      checkVal("hsync_on", int'(bus.hsync), 0);
      if (m_pix == HA + HFP + HS) checkVal("hsync_off", int'(bus.hsync), 1);
      if (m_pix == HT)            checkOutput("line_wrap", mk(1, 1, 1, 1, 1, 0, 0, 1));
    end

    // Continuous pix_ce: frame period, vsync width, active pixel count
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step(1'b1, 1'b1);
      found = bus.frame_start;
    end
    checkVal("first_frame_found", int'(found), 1);
    for (int f = 0; f < 2; f++) begin
      n = 0; vcnt = 0; acnt = 0;
      do begin
        if (!bus.vsync) vcnt++;
        if (bus.active) acnt++;
        step(1'b1, 1'b1);
        n++;
      end while (!bus.frame_start && n < 2 * FRAME);
      checkVal("frame_period", n, FRAME);
      checkVal("vsync_strobes", vcnt, VS * HT);
      checkVal("active_strobes", acnt, HA * VA);
    end

    // Stop requested at y=3 completes only at the frame end, without frame_start
    while (m_pix != 3 * HT) step(1'b1, 1'b1);
    n = 0; fs_seen = 0;
    do begin
      step(1'b0, 1'b1);
      n++;
      if (bus.frame_start) fs_seen++;
    end while (bus.running && n < 2 * FRAME);
    checkVal("stop_cycles", n, FRAME - 3 * HT);
    checkVal("stop_no_frame_start", fs_seen, 0);
    checkOutput("stopped_idle", mk(0, 0, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    checkOutput("idle_hold", mk(0, 0, 1, 1, 0, 0, 0, 0));

    // Stop request withdrawn before the frame end keeps the raster running
    step(1'b1, 1'b0);
    checkOutput("restart", mk(1, 1, 1, 1, 1, 1, 0, 0));
    drops = 0;
    for (int i = 0; i < 50; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1);
      if (!bus.running) drops++;
    end
    n = 0;
    do begin
      step(1'b1, 1'b1);
      n++;
      if (!bus.running) drops++;
    end while (!bus.frame_start && n < 2 * FRAME);
    checkVal("resume_no_drop", drops, 0);
    checkVal("resume_frame_start", int'(bus.frame_start), 1);

    // Reset mid-frame at (5,4), then immediate restart
    n = 0;
    while (m_pix != 4 * HT + 5 && n < 2 * FRAME) begin
      step(1'b1, 1'b1);
      n++;
    end
    checkVal("reach_5_4", m_pix, 4 * HT + 5);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("reset_mid", mk(0, 0, 1, 1, 0, 0, 0, 0));
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("reset_restart", mk(1, 1, 1, 1, 1, 1, 0, 0));

    // Randomised run against the model, with occasional stop requests and resets
    bus.en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic en_r, ce_r;
      en_r = ($urandom_range(0, 149) == 0) ? ~bus.en : bus.en;
      ce_r = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 999) == 0) begin
        applyStimulus(1'b0, en_r, ce_r);
        checkOutput("rand_reset", model_out());
      end else begin
        step(en_r, ce_r);
      end
    end

`ifdef VGA_FRAME_CNT_EN
    applyStimulus(1'b0, 1'b1, 1'b1);
    fs_seen = 0; n = 0;
    do begin
      step(1'b1, 1'b1);
      n++;
      if (bus.frame_start) fs_seen++;
    end while (fs_seen < 3 && n < 4 * FRAME);
    checkVal("three_frames", fs_seen, 3);
    checkVal("frame_cnt_after_3", int'(bus.frame_cnt), 2);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk_in);
    release dut.frame_cnt_q;
    m_fc = 16'hFFFF;
    n = 0;
    do begin
      step(1'b1, 1'b1);
      n++;
    end while (!bus.frame_start && n < 2 * FRAME);
    checkVal("frame_cnt_wrap", int'(bus.frame_cnt), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
